// File: rtl/mem_fill_initiator.sv
// Cache-side initiator for the main-memory line interface: one fill or writeback at a time,
// with address-range checking and a bounded wait on the memory handshake.
module mem_fill_initiator #(
    parameter int ADDR_LIMIT = 64000,
    parameter int TIMEOUT    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [26:0]  req_addr,
    input  logic [31:0]  req_be,
    input  logic [255:0] req_wdata,
    output logic         rsp_valid,
    output logic         rsp_err,
    output logic [255:0] rsp_rdata,
    output logic [26:0]  mem_a,
    output logic [31:0]  mem_be,
    output logic [255:0] mem_wd,
    output logic         mem_write,
    output logic         mem_read,
    input  logic [255:0] mem_rd,
    input  logic         mem_valid,
    input  logic         mem_ready
);

    localparam logic [26:0] ADDR_LIMIT_C = 27'(ADDR_LIMIT);
    localparam logic [7:0]  WAIT_LAST_C  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_STB   = 3'd1,
        RD_WAIT  = 3'd2,
        WR_SETUP = 3'd3,
        WR_STB   = 3'd4,
        WR_WAIT  = 3'd5,
        RESP     = 3'd6
    } state_t;

    state_t         state_r, state_s;
    logic [7:0]     cnt_r, cnt_s;
    logic           req_ready_r, req_ready_s;
    logic           rsp_valid_r, rsp_valid_s;
    logic           rsp_err_r, rsp_err_s;
    logic [255:0]   rsp_rdata_r, rsp_rdata_s;
    logic [26:0]    mem_a_r, mem_a_s;
    logic [31:0]    mem_be_r, mem_be_s;
    logic [255:0]   mem_wd_r, mem_wd_s;
    logic           mem_write_r, mem_write_s;
    logic           mem_read_r, mem_read_s;

    // Next-state and next-output decode; every output is computed one cycle ahead and registered.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        rsp_rdata_s = rsp_rdata_r;
        mem_a_s     = mem_a_r;
        mem_be_s    = mem_be_r;
        mem_wd_s    = mem_wd_r;
        mem_write_s = 1'b0;
        mem_read_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    if (req_addr >= ADDR_LIMIT_C) begin
                        state_s     = RESP;
                        rsp_valid_s = 1'b1;
                        rsp_err_s   = 1'b1;
                    end else if (req_write) begin
                        state_s  = WR_SETUP;
                        mem_a_s  = req_addr;
                        mem_be_s = req_be;
                        mem_wd_s = req_wdata;
                    end else begin
                        state_s    = RD_STB;
                        mem_a_s    = req_addr;
                        mem_read_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD_STB: begin
                state_s = RD_WAIT;
                cnt_s   = 8'd0;
            end
            RD_WAIT: begin
                // A handshake on the last allowed wait cycle still wins over the timeout.
                if (mem_valid) begin
                    state_s     = RESP;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = mem_rd;
                end else if (cnt_r == WAIT_LAST_C) begin
                    state_s     = RESP;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            WR_SETUP: begin
                state_s     = WR_STB;
                mem_write_s = 1'b1;
            end
            WR_STB: begin
                state_s = WR_WAIT;
                cnt_s   = 8'd0;
            end
            WR_WAIT: begin
                if (mem_ready) begin
                    state_s     = RESP;
                    rsp_valid_s = 1'b1;
                end else if (cnt_r == WAIT_LAST_C) begin
                    state_s     = RESP;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        req_ready_s = (state_s == IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 256'd0;
            mem_a_r     <= 27'd0;
            mem_be_r    <= 32'd0;
            mem_wd_r    <= 256'd0;
            mem_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            req_ready_r <= req_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_err_r   <= rsp_err_s;
            rsp_rdata_r <= rsp_rdata_s;
            mem_a_r     <= mem_a_s;
            mem_be_r    <= mem_be_s;
            mem_wd_r    <= mem_wd_s;
            mem_write_r <= mem_write_s;
            mem_read_r  <= mem_read_s;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;
    assign mem_a     = mem_a_r;
    assign mem_be    = mem_be_r;
    assign mem_wd    = mem_wd_r;
    assign mem_write = mem_write_r;
    assign mem_read  = mem_read_r;

endmodule

// File: tb/tb_mem_fill_initiator.sv
// Randomized scoreboard bench for mem_fill_initiator: a memory responder on the mem_* side,
// a request driver that predicts each response, and a monitor that checks responses in order.
module tb_mem_fill_initiator;

    localparam int TMO = 16;
    localparam int LIM = 64000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [26:0]  req_addr = 27'd0;
    logic [31:0]  req_be = 32'd0;
    logic [255:0] req_wdata = 256'd0;
    logic         rsp_valid;
    logic         rsp_err;
    logic [255:0] rsp_rdata;
    logic [26:0]  mem_a;
    logic [31:0]  mem_be;
    logic [255:0] mem_wd;
    logic         mem_write;
    logic         mem_read;
    logic [255:0] mem_rd = 256'd0;
    logic         mem_valid = 1'b0;
    logic         mem_ready = 1'b0;

    mem_fill_initiator #(.ADDR_LIMIT(LIM), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_a(mem_a), .mem_be(mem_be), .mem_wd(mem_wd),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_rd(mem_rd), .mem_valid(mem_valid), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct { bit wr; bit err; logic [255:0] rdata; int cyc; } exp_t;
    typedef struct { bit wr; int cyc; int d; logic [26:0] a; } stb_t;
    exp_t sbq[$];
    stb_t stq[$];

    logic [255:0] ref_mem [int];
    logic [255:0] env_mem [int];
    logic [255:0] exp_last = 256'd0;
    bit spur_en = 1'b1;
    bit inj_valid = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] wd,
                                           input logic [31:0] be);
        logic [255:0] r = old;
        for (int b = 0; b < 32; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [255:0] get_ref(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 256'd0;
    endfunction

    function automatic logic [255:0] get_env(input int a);
        return env_mem.exists(a) ? env_mem[a] : 256'd0;
    endfunction

    // Response monitor: pops the scoreboard on every rsp_valid and watches strobe spacing.
    bit prev_stb = 1'b0;
    int busy = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("strobe_overlap", {255'd0, mem_read & mem_write}, 256'd0);
            chk("strobe_adjacent", {255'd0, (mem_read | mem_write) & prev_stb}, 256'd0);
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_rsp at cycle %0d: got rsp_valid=1 expected none", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_err", {255'd0, rsp_err}, {255'd0, e.err});
                    chk("rsp_cycle", 256'(cyc), 256'(e.cyc));
                    if (!e.wr) chk("rsp_rdata", rsp_rdata, e.rdata);
                end
                busy = 0;
            end else begin
                chk("err_without_valid", {255'd0, rsp_err}, 256'd0);
            end
        end
        prev_stb = mem_read | mem_write;
    end

    // Memory responder: applies writes, returns reads after the scheduled delay, injects noise.
    int resp_cyc = -1;
    bit resp_wr = 1'b0;
    logic [26:0] resp_addr = 27'd0;
    logic [26:0] prev_a = 27'd0;
    always @(negedge clk) begin
        stb_t s;
        mem_valid = 1'b0;
        mem_ready = 1'b0;
        mem_rd    = rnd256();
        if (!rst_n) begin
            resp_cyc = -1;
            busy     = 0;
        end else begin
            if (mem_read || mem_write) begin
                if (stq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_strobe at cycle %0d: got read=%0b write=%0b expected none",
                             cyc, mem_read, mem_write);
                end else begin
                    s = stq.pop_front();
                    chk("strobe_kind", {255'd0, mem_write}, {255'd0, s.wr});
                    chk("strobe_cycle", 256'(cyc), 256'(s.cyc));
                    chk("strobe_addr", {229'd0, mem_write ? prev_a : mem_a}, {229'd0, s.a});
                    if (mem_write) env_mem[int'(prev_a)] = merge(get_env(int'(prev_a)), mem_wd, mem_be);
                    busy      = mem_write ? 2 : 1;
                    resp_wr   = mem_write;
                    resp_addr = mem_a;
                    resp_cyc  = (s.d <= TMO) ? cyc + s.d : -1;
                end
            end
            if (resp_cyc == cyc) begin
                if (resp_wr) mem_ready = 1'b1;
                else begin
                    mem_valid = 1'b1;
                    mem_rd    = get_env(int'(resp_addr));
                end
                resp_cyc = -1;
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                if (busy == 1) mem_ready = 1'b1;
                else if (busy == 2) mem_valid = 1'b1;
                else if ($urandom_range(0, 1) == 1) mem_valid = 1'b1;
                else mem_ready = 1'b1;
            end
            if (inj_valid) begin
                mem_valid = 1'b1;
                inj_valid = 1'b0;
            end
        end
        prev_a = mem_a;
    end

    // Issue one request (called at a negedge) and record what the reference predicts for it.
    task automatic do_req(input bit wr, input logic [26:0] a, input logic [31:0] be,
                          input logic [255:0] wd, input int d, input bit hold);
        int waited = 0;
        int t;
        bit ok;
        req_write = wr; req_addr = a; req_be = be; req_wdata = wd; req_valid = 1'b1;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL req_ready_timeout at cycle %0d: got req_ready=0 expected 1", cyc);
            req_valid = 1'b0;
            return;
        end
        t  = cyc;
        ok = (d <= TMO);
        if (int'(a) >= LIM) begin
            sbq.push_back('{wr, 1'b1, exp_last, t + 1});
        end else if (wr) begin
            stq.push_back('{1'b1, t + 2, d, a});
            ref_mem[int'(a)] = merge(get_ref(int'(a)), wd, be);
            sbq.push_back('{1'b1, !ok, exp_last, ok ? t + d + 3 : t + TMO + 3});
        end else begin
            stq.push_back('{1'b0, t + 1, d, a});
            if (ok) exp_last = get_ref(int'(a));
            sbq.push_back('{1'b0, !ok, exp_last, ok ? t + d + 2 : t + TMO + 2});
        end
        @(posedge clk);
        @(negedge clk);
        req_write = $urandom_range(0, 1) == 1;
        req_addr  = 27'($urandom());
        req_be    = $urandom();
        req_wdata = rnd256();
        req_valid = hold;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, {255'd0, req_ready}, {255'd0, 1'b1});
        chk({tag, "_rsp_valid"}, {255'd0, rsp_valid}, 256'd0);
        chk({tag, "_mem_read"}, {255'd0, mem_read}, 256'd0);
        chk({tag, "_mem_write"}, {255'd0, mem_write}, 256'd0);
        chk({tag, "_mem_a"}, {229'd0, mem_a}, 256'd0);
        chk({tag, "_mem_be"}, {224'd0, mem_be}, 256'd0);
        chk({tag, "_mem_wd"}, mem_wd, 256'd0);
    endtask

    initial begin
        logic [255:0] a5 = {32{8'hA5}};
        int waited;
        int r;
        logic [26:0] ra;

        repeat (3) @(negedge clk);
        chk_quiet("reset");
        chk("reset_rsp_err", {255'd0, rsp_err}, 256'd0);
        chk("reset_rsp_rdata", rsp_rdata, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        env_mem[16] = a5;
        ref_mem[16] = a5;
        do_req(1'b0, 27'h10, 32'd0, 256'd0, 2, 1'b0);
        do_req(1'b1, 27'h3, 32'hFFFF_FFFF, 256'h1234, 2, 1'b0);
        do_req(1'b0, 27'h3, 32'd0, 256'd0, 2, 1'b0);
        do_req(1'b0, 27'(LIM), 32'd0, 256'd0, 2, 1'b0);
        do_req(1'b1, 27'(LIM), 32'hFFFF_FFFF, rnd256(), 2, 1'b0);
        do_req(1'b0, 27'(LIM - 1), 32'd0, 256'd0, 1, 1'b0);
        do_req(1'b0, 27'h10, 32'd0, 256'd0, TMO + 1, 1'b0);
        do_req(1'b0, 27'h10, 32'd0, 256'd0, TMO, 1'b0);
        do_req(1'b1, 27'h4, 32'h0F0F_00FF, rnd256(), TMO + 1, 1'b0);
        do_req(1'b1, 27'h4, 32'hF0F0_FF00, rnd256(), TMO, 1'b0);
        do_req(1'b0, 27'h4, 32'd0, 256'd0, 3, 1'b0);

        // Back-to-back with req_valid held high throughout.
        do_req(1'b0, 27'h10, 32'd0, 256'd0, 2, 1'b1);
        do_req(1'b1, 27'h5, 32'h00FF_FF00, rnd256(), 3, 1'b1);
        do_req(1'b0, 27'h5, 32'd0, 256'd0, 1, 1'b1);
        req_valid = 1'b0;

        // Reset in the middle of a fill wait, then a late mem_valid.
        waited = 0;
        while (sbq.size() != 0 && waited < 200) begin @(negedge clk); waited++; end
        spur_en = 1'b0;
        do_req(1'b0, 27'h6, 32'd0, 256'd0, TMO + 5, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        stq.delete();
        exp_last = 256'd0;
        @(negedge clk);
        chk_quiet("midreset");
        rst_n = 1'b1;
        @(negedge clk);
        inj_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk_quiet("post_reset");
        do_req(1'b0, 27'h10, 32'd0, 256'd0, TMO + 1, 1'b0);
        spur_en = 1'b1;

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) ra = 27'(LIM + $urandom_range(0, 3));
            else if (r == 1) ra = 27'h7FF_FFFF;
            else if (r == 2) ra = 27'(LIM - 1);
            else ra = 27'($urandom_range(0, 7));
            do_req($urandom_range(0, 1) == 1, ra, $urandom(), rnd256(),
                   ($urandom_range(0, 5) == 0) ? TMO + 1 :
                   (($urandom_range(0, 2) == 0) ? $urandom_range(1, TMO) : $urandom_range(1, 3)),
                   $urandom_range(0, 1) == 1);
        end
        req_valid = 1'b0;

        waited = 0;
        while (sbq.size() != 0 && waited < 200) begin @(negedge clk); waited++; end
        if (sbq.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain: got %0d pending responses expected 0", sbq.size());
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
